kftvga_bus_responder: RTL and testbench



---
 rtl/kftvga_bus_responder_if.sv | 46 ++++
 rtl/kftvga_bus_responder.sv | 243 ++++++++++++++++++++++++
 tb/tb_kftvga_bus_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/kftvga_bus_responder_if.sv
// KFTVGA host bus plus synchronous VRAM port, bundled for the bus responder.
// The responder attaches through the slave modport; the host/VRAM side uses master.
interface kftvga_bus_responder_if;
   logic        chip_select_n;
   logic        write_enable_n;
   logic        read_enable_n;
   logic [13:0] address;
   logic [7:0]  data_bus_in;
   logic [7:0]  data_bus_out;
   logic [13:0] vram_address;
   logic [7:0]  vram_write_data;
   logic        vram_write_enable;
   logic        vram_read_enable;
   logic [7:0]  vram_read_data;
   logic        bus_error;

   modport slave (
      input  chip_select_n,
      input  write_enable_n,
      input  read_enable_n,
      input  address,
      input  data_bus_in,
      input  vram_read_data,
      output data_bus_out,
      output vram_address,
      output vram_write_data,
      output vram_write_enable,
      output vram_read_enable,
      output bus_error
   );

   modport master (
      output chip_select_n,
      output write_enable_n,
      output read_enable_n,
      output address,
      output data_bus_in,
      output vram_read_data,
      input  data_bus_out,
      input  vram_address,
      input  vram_write_data,
      input  vram_write_enable,
      input  vram_read_enable,
      input  bus_error
   );
endinterface

// File: rtl/kftvga_bus_responder.sv
// KFTVGA bus responder: turns each completed host strobe into exactly one
// single-cycle VRAM access; out-of-range accesses are dropped and flagged.
module kftvga_bus_responder #(
   parameter int VRAM_SIZE  = 9600,
   parameter int RD_LATENCY = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   kftvga_bus_responder_if.slave         bus
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_HOLD  = 3'd1,
      RD_ISSUE = 3'd2,
      RD_WAIT  = 3'd3,
      RD_HOLD  = 3'd4
   } state_t;

   localparam logic [14:0] VRAM_LIMIT = 15'(VRAM_SIZE);
   localparam logic [3:0]  LAT_LAST   = 4'(RD_LATENCY - 1);

   // Full 14-bit unsigned compare, widened so VRAM_SIZE = 16384 still works.
   function automatic logic in_range(input logic [13:0] addr);
      return ({1'b0, addr} < VRAM_LIMIT);
   endfunction

   state_t      state_r;
   state_t      next_state_s;

   logic        cs_n_r;
   logic        we_n_r;
   logic        re_n_r;
   logic [13:0] addr_r;
   logic [7:0]  din_r;

   logic [13:0] lat_addr_r;
   logic [7:0]  lat_data_r;
   logic        rd_pend_r;
   logic        rd_oor_r;
   logic [3:0]  wait_cnt_r;

   logic [7:0]  data_bus_out_r;
   logic [13:0] vram_address_r;
   logic [7:0]  vram_write_data_r;
   logic        vram_write_enable_r;
   logic        vram_read_enable_r;
   logic        bus_error_r;

   logic        wr_act_s;
   logic        rd_act_s;
   logic        latch_wr_s;
   logic        commit_wr_s;
   logic        issue_rd_s;
   logic [13:0] issue_addr_s;
   logic        capture_s;
   logic        set_pend_s;
   logic        clr_pend_s;

   assign wr_act_s = ~cs_n_r & ~we_n_r;
   assign rd_act_s = ~cs_n_r & ~re_n_r & we_n_r;

   // Input stage: every host signal is registered before decoding.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cs_n_r <= 1'b1;
         we_n_r <= 1'b1;
         re_n_r <= 1'b1;
         addr_r <= 14'd0;
         din_r  <= 8'd0;
      end else begin
         cs_n_r <= bus.chip_select_n;
         we_n_r <= bus.write_enable_n;
         re_n_r <= bus.read_enable_n;
         addr_r <= bus.address;
         din_r  <= bus.data_bus_in;
      end
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and datapath control decode.
   always_comb begin
      next_state_s = state_r;
      latch_wr_s   = 1'b0;
      commit_wr_s  = 1'b0;
      issue_rd_s   = 1'b0;
      issue_addr_s = addr_r;
      capture_s    = 1'b0;
      set_pend_s   = 1'b0;
      clr_pend_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (wr_act_s) begin
               next_state_s = WR_HOLD;
               latch_wr_s   = 1'b1;
            end else if (rd_act_s) begin
               next_state_s = RD_ISSUE;
               issue_rd_s   = 1'b1;
               issue_addr_s = addr_r;
            end else begin
               next_state_s = IDLE;
            end
         end
         WR_HOLD: begin
            if (wr_act_s) begin
               next_state_s = WR_HOLD;
               latch_wr_s   = 1'b1;
            end else begin
               commit_wr_s = 1'b1;
               // A read arriving with the release waits one clock so the
               // write and read pulses never overlap.
               if (rd_act_s) begin
                  next_state_s = RD_ISSUE;
                  set_pend_s   = 1'b1;
               end else begin
                  next_state_s = IDLE;
               end
            end
         end
         RD_ISSUE: begin
            if (rd_pend_r) begin
               next_state_s = RD_ISSUE;
               issue_rd_s   = 1'b1;
               issue_addr_s = lat_addr_r;
               clr_pend_s   = 1'b1;
            end else begin
               next_state_s = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (wait_cnt_r == LAT_LAST) begin
               capture_s = 1'b1;
               if (wr_act_s) begin
                  next_state_s = WR_HOLD;
                  latch_wr_s   = 1'b1;
               end else begin
                  next_state_s = RD_HOLD;
               end
            end else begin
               next_state_s = RD_WAIT;
            end
         end
         RD_HOLD: begin
            if (wr_act_s) begin
               next_state_s = WR_HOLD;
               latch_wr_s   = 1'b1;
            end else if (!rd_act_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = RD_HOLD;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Access latches, pending-read flag and read-latency counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lat_addr_r <= 14'd0;
         lat_data_r <= 8'd0;
         rd_pend_r  <= 1'b0;
         wait_cnt_r <= 4'd0;
      end else begin
         if (latch_wr_s) begin
            lat_addr_r <= addr_r;
            lat_data_r <= din_r;
         end else if (set_pend_s) begin
            lat_addr_r <= addr_r;
         end else begin
            lat_addr_r <= lat_addr_r;
         end
         if (set_pend_s) begin
            rd_pend_r <= 1'b1;
         end else if (clr_pend_s) begin
            rd_pend_r <= 1'b0;
         end else begin
            rd_pend_r <= rd_pend_r;
         end
         if ((state_r == RD_WAIT) && !capture_s) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
         end else begin
            wait_cnt_r <= 4'd0;
         end
      end
   end

   // VRAM port, read-data return and sticky error flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vram_write_enable_r <= 1'b0;
         vram_read_enable_r  <= 1'b0;
         vram_address_r      <= 14'd0;
         vram_write_data_r   <= 8'd0;
         data_bus_out_r      <= 8'd0;
         bus_error_r         <= 1'b0;
         rd_oor_r            <= 1'b0;
      end else begin
         vram_write_enable_r <= 1'b0;
         vram_read_enable_r  <= 1'b0;
         if (commit_wr_s) begin
            if (in_range(lat_addr_r)) begin
               vram_write_enable_r <= 1'b1;
               vram_address_r      <= lat_addr_r;
               vram_write_data_r   <= lat_data_r;
            end else begin
               bus_error_r <= 1'b1;
            end
         end
         if (issue_rd_s) begin
            if (in_range(issue_addr_s)) begin
               vram_read_enable_r <= 1'b1;
               vram_address_r     <= issue_addr_s;
               rd_oor_r           <= 1'b0;
            end else begin
               rd_oor_r    <= 1'b1;
               bus_error_r <= 1'b1;
            end
         end
         if (capture_s) begin
            data_bus_out_r <= rd_oor_r ? 8'h00 : bus.vram_read_data;
         end
      end
   end

   assign bus.data_bus_out      = data_bus_out_r;
   assign bus.vram_address      = vram_address_r;
   assign bus.vram_write_data   = vram_write_data_r;
   assign bus.vram_write_enable = vram_write_enable_r;
   assign bus.vram_read_enable  = vram_read_enable_r;
   assign bus.bus_error         = bus_error_r;

endmodule

// File: tb/tb_kftvga_bus_responder.sv
// Directed bench for kftvga_bus_responder with a behavioural 1-clock VRAM.
// Inputs change 1 time unit after the rising edge; outputs are checked at the falling edge.
module tb_kftvga_bus_responder;

   logic clock = 1'b0;
   logic reset;
   int   vectors    = 0;
   int   miscompares = 0;
   int   wp_cnt     = 0;
   int   rp_cnt     = 0;
   int   both_cnt   = 0;
   int   snap_w;
   int   snap_r;

   always #5 clock = ~clock;

   kftvga_bus_responder_if bus_if ();

   kftvga_bus_responder #(.VRAM_SIZE(9600), .RD_LATENCY(1)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   logic [7:0] mem [0:16383];

   always @(posedge clock) begin
      if (bus_if.vram_write_enable) mem[bus_if.vram_address] <= bus_if.vram_write_data;
      if (bus_if.vram_read_enable) bus_if.vram_read_data <= mem[bus_if.vram_address];
   end

   always @(negedge clock) begin
      if (bus_if.vram_write_enable) wp_cnt++;
      if (bus_if.vram_read_enable) rp_cnt++;
      if (bus_if.vram_write_enable && bus_if.vram_read_enable) both_cnt++;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic cs, input logic we, input logic re,
                      input logic [13:0] a, input logic [7:0] d);
      @(posedge clock);
      #1;
      bus_if.chip_select_n  = cs;
      bus_if.write_enable_n = we;
      bus_if.read_enable_n  = re;
      bus_if.address        = a;
      bus_if.data_bus_in    = d;
      @(negedge clock);
   endtask

   task automatic idle();
      cyc(1'b1, 1'b1, 1'b1, 14'd0, 8'h00);
   endtask

   initial begin
      reset                 = 1'b1;
      bus_if.chip_select_n  = 1'b1;
      bus_if.write_enable_n = 1'b1;
      bus_if.read_enable_n  = 1'b1;
      bus_if.address        = 14'd0;
      bus_if.data_bus_in    = 8'h00;
      repeat (2) @(negedge clock);
      chk("rst_dbo", 16'(bus_if.data_bus_out), 16'h0000);
      chk("rst_vaddr", 16'(bus_if.vram_address), 16'h0000);
      chk("rst_wdata", 16'(bus_if.vram_write_data), 16'h0000);
      chk("rst_we", 16'(bus_if.vram_write_enable), 16'h0000);
      chk("rst_re", 16'(bus_if.vram_read_enable), 16'h0000);
      chk("rst_err", 16'(bus_if.bus_error), 16'h0000);
      reset = 1'b0;
      idle();

      // Host 4-clock rhythm: (2,0x48) then (3,0x01)
      cyc(1'b0, 1'b0, 1'b1, 14'd2, 8'h48);
      chk("rhy_we0", 16'(bus_if.vram_write_enable), 16'h0000);
      cyc(1'b0, 1'b1, 1'b1, 14'd2, 8'h48);
      chk("rhy_we1", 16'(bus_if.vram_write_enable), 16'h0000);
      cyc(1'b0, 1'b0, 1'b1, 14'd3, 8'h01);
      chk("rhy_we2", 16'(bus_if.vram_write_enable), 16'h0000);
      cyc(1'b0, 1'b1, 1'b1, 14'd3, 8'h01);
      chk("rhy_we3", 16'(bus_if.vram_write_enable), 16'h0001);
      chk("rhy_addr3", 16'(bus_if.vram_address), 16'h0002);
      chk("rhy_data3", 16'(bus_if.vram_write_data), 16'h0048);
      idle();
      chk("rhy_we4", 16'(bus_if.vram_write_enable), 16'h0000);
      idle();
      chk("rhy_we5", 16'(bus_if.vram_write_enable), 16'h0001);
      chk("rhy_addr5", 16'(bus_if.vram_address), 16'h0003);
      chk("rhy_data5", 16'(bus_if.vram_write_data), 16'h0001);
      idle();
      chk("rhy_we6", 16'(bus_if.vram_write_enable), 16'h0000);
      chk("rhy_re", 16'(bus_if.vram_read_enable), 16'h0000);

      // Write strobe held 5 clocks, data 0x10..0x14 at address 100
      snap_w = wp_cnt;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 14'd100, 8'(8'h10 + i));
         chk("hold_we", 16'(bus_if.vram_write_enable), 16'h0000);
      end
      cyc(1'b1, 1'b1, 1'b1, 14'd100, 8'h14);
      chk("hold_rel", 16'(bus_if.vram_write_enable), 16'h0000);
      idle();
      chk("hold_k", 16'(bus_if.vram_write_enable), 16'h0000);
      idle();
      chk("hold_pulse", 16'(bus_if.vram_write_enable), 16'h0001);
      chk("hold_addr", 16'(bus_if.vram_address), 16'h0064);
      chk("hold_data", 16'(bus_if.vram_write_data), 16'h0014);
      idle();
      idle();
      chk("hold_count", 16'(wp_cnt - snap_w), 16'h0001);

      // Preload VRAM[9599]=0xA5 through the bus, then read it with a 6-clock strobe
      cyc(1'b0, 1'b0, 1'b1, 14'd9599, 8'hA5);
      cyc(1'b0, 1'b1, 1'b1, 14'd9599, 8'hA5);
      repeat (3) idle();
      snap_r = rp_cnt;
      cyc(1'b0, 1'b1, 1'b0, 14'd9599, 8'h00);
      chk("rd_re0", 16'(bus_if.vram_read_enable), 16'h0000);
      cyc(1'b0, 1'b1, 1'b0, 14'd9599, 8'h00);
      chk("rd_re1", 16'(bus_if.vram_read_enable), 16'h0000);
      cyc(1'b0, 1'b1, 1'b0, 14'd9599, 8'h00);
      chk("rd_re2", 16'(bus_if.vram_read_enable), 16'h0001);
      chk("rd_addr2", 16'(bus_if.vram_address), 16'h257F);
      cyc(1'b0, 1'b1, 1'b0, 14'd9599, 8'h00);
      chk("rd_re3", 16'(bus_if.vram_read_enable), 16'h0000);
      chk("rd_dbo3", 16'(bus_if.data_bus_out), 16'h0000);
      cyc(1'b0, 1'b1, 1'b0, 14'd9599, 8'h00);
      chk("rd_dbo4", 16'(bus_if.data_bus_out), 16'h00A5);
      cyc(1'b0, 1'b1, 1'b0, 14'd9599, 8'h00);
      chk("rd_re5", 16'(bus_if.vram_read_enable), 16'h0000);
      repeat (3) idle();
      chk("rd_dbo_held", 16'(bus_if.data_bus_out), 16'h00A5);
      chk("rd_count", 16'(rp_cnt - snap_r), 16'h0001);

      // Out-of-range write to 9600 and read of 16383
      chk("oor_err_before", 16'(bus_if.bus_error), 16'h0000);
      snap_w = wp_cnt;
      cyc(1'b0, 1'b0, 1'b1, 14'd9600, 8'h77);
      cyc(1'b0, 1'b1, 1'b1, 14'd9600, 8'h77);
      repeat (3) idle();
      chk("oor_wr_count", 16'(wp_cnt - snap_w), 16'h0000);
      chk("oor_wr_err", 16'(bus_if.bus_error), 16'h0001);
      snap_r = rp_cnt;
      repeat (3) cyc(1'b0, 1'b1, 1'b0, 14'd16383, 8'h00);
      idle();
      chk("oor_dbo_old", 16'(bus_if.data_bus_out), 16'h00A5);
      idle();
      chk("oor_dbo_zero", 16'(bus_if.data_bus_out), 16'h0000);
      repeat (2) idle();
      chk("oor_rd_count", 16'(rp_cnt - snap_r), 16'h0000);
      chk("oor_err_sticky", 16'(bus_if.bus_error), 16'h0001);

      // Write release and read assertion sampled together at address 4
      cyc(1'b0, 1'b0, 1'b1, 14'd4, 8'h3C);
      cyc(1'b0, 1'b1, 1'b0, 14'd4, 8'h3C);
      cyc(1'b0, 1'b1, 1'b0, 14'd4, 8'h3C);
      chk("wr_rd_we_k", 16'(bus_if.vram_write_enable), 16'h0000);
      cyc(1'b0, 1'b1, 1'b0, 14'd4, 8'h3C);
      chk("wr_rd_we", 16'(bus_if.vram_write_enable), 16'h0001);
      chk("wr_rd_re_k1", 16'(bus_if.vram_read_enable), 16'h0000);
      chk("wr_rd_waddr", 16'(bus_if.vram_address), 16'h0004);
      cyc(1'b0, 1'b1, 1'b0, 14'd4, 8'h3C);
      chk("wr_rd_re", 16'(bus_if.vram_read_enable), 16'h0001);
      chk("wr_rd_we_k2", 16'(bus_if.vram_write_enable), 16'h0000);
      chk("wr_rd_raddr", 16'(bus_if.vram_address), 16'h0004);
      idle();
      idle();
      chk("wr_rd_dbo", 16'(bus_if.data_bus_out), 16'h003C);
      idle();

      // Reset while in WR_HOLD: write dropped, outputs back to reset values
      snap_w = wp_cnt;
      repeat (3) cyc(1'b0, 1'b0, 1'b1, 14'd6, 8'h99);
      reset = 1'b1;
      #1;
      chk("mid_dbo", 16'(bus_if.data_bus_out), 16'h0000);
      chk("mid_err", 16'(bus_if.bus_error), 16'h0000);
      chk("mid_vaddr", 16'(bus_if.vram_address), 16'h0000);
      chk("mid_wdata", 16'(bus_if.vram_write_data), 16'h0000);
      repeat (2) idle();
      chk("mid_we", 16'(bus_if.vram_write_enable), 16'h0000);
      reset = 1'b0;
      repeat (3) idle();
      chk("mid_dropped", 16'(wp_cnt - snap_w), 16'h0000);
      cyc(1'b0, 1'b0, 1'b1, 14'd8, 8'h5A);
      cyc(1'b0, 1'b1, 1'b1, 14'd8, 8'h5A);
      idle();
      chk("post_we_k", 16'(bus_if.vram_write_enable), 16'h0000);
      idle();
      chk("post_we", 16'(bus_if.vram_write_enable), 16'h0001);
      chk("post_addr", 16'(bus_if.vram_address), 16'h0008);
      chk("post_data", 16'(bus_if.vram_write_data), 16'h005A);
      idle();
      chk("never_both", 16'(both_cnt), 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
